pipe_hazard_ctrl: RTL and testbench

- Control-side driver of the latch-enable (latchn) and flush inputs on the IF/ID and ID/EX pipeline registers, plus the PC-register enable.
- Detects load-use hazards and resolves branch mispredictions using the EX-stage taken result against the carried bpr bit, and issues the PC redirect.
- Sequences halt: drains the pipeline after a confirmed halt, then freezes it.
- Sits beside the datapath, between the EX-stage outputs and the pipeline registers.

---
 rtl/pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, mispredict redirect/flush and halt drain.
// Define PIPE_HAZARD_CTRL_STATS_EN to add saturating stall/flush/run-cycle counters.
module pipe_hazard_ctrl #(
    parameter int unsigned PC_W         = 12,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic            ex_valid,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd,
    input  logic            ex_is_branch,
    input  logic            ex_taken,
    input  logic            ex_bpr,
    input  logic [PC_W-1:0] ex_target,
    input  logic [PC_W-1:0] ex_pc_next,
    input  logic            ex_halt,
    output logic            pc_latchn,
    output logic            if_id_latchn,
    output logic            id_ex_latchn,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            halted
`ifdef PIPE_HAZARD_CTRL_STATS_EN
    ,
    output logic [15:0]     stall_cnt,
    output logic [15:0]     flush_cnt,
    output logic [15:0]     cycle_cnt
`endif
);

    localparam int unsigned CNT_W      = 4;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic mispredict_c;
    logic halt_c;
    logic load_use_c;

    assign mispredict_c = ex_valid & ex_is_branch & (ex_taken != ex_bpr);
    assign halt_c       = ex_valid & ex_halt;
    assign load_use_c   = ex_valid & ex_is_load & (ex_rd != 5'd0) & id_valid &
                          ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                           (id_uses_rs2 & (id_rs2 == ex_rd)));

    // State and drain counter
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and pipeline controls; reset values are forced while RSTn is low
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_latchn      = 1'b1;
        if_id_latchn   = 1'b1;
        id_ex_latchn   = 1'b1;
        if_id_flush    = 1'b1;
        id_ex_flush    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halted         = 1'b0;

        if (RSTn) begin
            case (state_q)
                ST_INIT: begin
                    pc_latchn    = 1'b0;
                    if_id_latchn = 1'b0;
                    id_ex_latchn = 1'b0;
                    state_d      = ST_RUN;
                end
                ST_RUN: begin
                    pc_latchn    = 1'b0;
                    if_id_latchn = 1'b0;
                    id_ex_latchn = 1'b0;
                    if_id_flush  = 1'b0;
                    id_ex_flush  = 1'b0;
                    // Mispredict outranks halt and load-use: the ID instruction is wrong-path
                    if (mispredict_c) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = ex_taken ? ex_target : ex_pc_next;
                        if_id_flush    = 1'b1;
                        id_ex_flush    = 1'b1;
                    end else if (halt_c) begin
                        pc_latchn   = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        cnt_d       = DRAIN_LOAD;
                        state_d     = ST_DRAIN;
                    end else if (load_use_c) begin
                        pc_latchn    = 1'b1;
                        if_id_latchn = 1'b1;
                        id_ex_flush  = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if_id_latchn = 1'b0;
                    id_ex_latchn = 1'b0;
                    if (cnt_q == '0) begin
                        state_d = ST_HALTED;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_HALTED: begin
                    if_id_flush = 1'b0;
                    id_ex_flush = 1'b0;
                    halted      = 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_HAZARD_CTRL_STATS_EN
    logic        in_run_c;
    logic        stall_cyc_c;
    logic        redirect_cyc_c;
    logic [15:0] stall_cnt_q, flush_cnt_q, cycle_cnt_q;

    assign in_run_c       = (state_q == ST_RUN);
    assign redirect_cyc_c = in_run_c & mispredict_c;
    assign stall_cyc_c    = in_run_c & ~mispredict_c & ~halt_c & load_use_c;

    // Saturating event counters; they only advance in RUN, so they freeze once halted
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            if (stall_cyc_c && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (redirect_cyc_c && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
            if (in_run_c && (cycle_cnt_q != 16'hFFFF)) cycle_cnt_q <= cycle_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed cases then randomized segments
// against a cycle-indexed behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned PC_W         = 12;
    localparam int unsigned DRAIN_CYCLES = 3;

    logic            CLK;
    logic            RSTn;
    logic            id_valid;
    logic [4:0]      id_rs1, id_rs2;
    logic            id_uses_rs1, id_uses_rs2;
    logic            ex_valid, ex_is_load;
    logic [4:0]      ex_rd;
    logic            ex_is_branch, ex_taken, ex_bpr;
    logic [PC_W-1:0] ex_target, ex_pc_next;
    logic            ex_halt;
    logic            pc_latchn, if_id_latchn, id_ex_latchn;
    logic            if_id_flush, id_ex_flush;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            halted;
`ifdef PIPE_HAZARD_CTRL_STATS_EN
    logic [15:0]     stall_cnt, flush_cnt, cycle_cnt;
`endif

    pipe_hazard_ctrl #(
        .PC_W         (PC_W),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_valid       (ex_valid),
        .ex_is_load     (ex_is_load),
        .ex_rd          (ex_rd),
        .ex_is_branch   (ex_is_branch),
        .ex_taken       (ex_taken),
        .ex_bpr         (ex_bpr),
        .ex_target      (ex_target),
        .ex_pc_next     (ex_pc_next),
        .ex_halt        (ex_halt),
        .pc_latchn      (pc_latchn),
        .if_id_latchn   (if_id_latchn),
        .id_ex_latchn   (id_ex_latchn),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
`ifdef PIPE_HAZARD_CTRL_STATS_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
        .cycle_cnt      (cycle_cnt)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int vectors     = 0;
    int miscompares = 0;

    // Model state: cycles since reset release, and the cycle index at which halted begins
    int          cyc     = 0;
    int          halt_at = -1;
    logic [15:0] m_stall = '0;
    logic [15:0] m_flush = '0;
    logic [15:0] m_run   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic next_cycle();
        @(negedge CLK);
        RSTn         = 1'b1;
        id_valid     = 1'b0;
        id_rs1       = 5'd0;
        id_rs2       = 5'd0;
        id_uses_rs1  = 1'b0;
        id_uses_rs2  = 1'b0;
        ex_valid     = 1'b0;
        ex_is_load   = 1'b0;
        ex_rd        = 5'd0;
        ex_is_branch = 1'b0;
        ex_taken     = 1'b0;
        ex_bpr       = 1'b0;
        ex_target    = '0;
        ex_pc_next   = '0;
        ex_halt      = 1'b0;
    endtask

    // Evaluate expected outputs for the current inputs, compare, then advance the model one clock
    task automatic check(input string tag);
        logic [6:0]      ectl;
        logic [6:0]      octl;
        logic [PC_W-1:0] epc;
        logic [31:0]     reads;
        bit              running, mis, hlt, hz;
        #1;
        running = 0; mis = 0; hlt = 0; hz = 0;
        epc   = '0;
        reads = '0;
        if (id_uses_rs1) reads[id_rs1] = 1'b1;
        if (id_uses_rs2) reads[id_rs2] = 1'b1;
        // {pc_latchn, if_id_latchn, id_ex_latchn, if_id_flush, id_ex_flush, redirect_valid, halted}
        if (!RSTn)                            ectl = 7'b1111100;
        else if (cyc == 0)                    ectl = 7'b0001100;
        else if (halt_at >= 0 && cyc >= halt_at) ectl = 7'b1110001;
        else if (halt_at >= 0)                ectl = 7'b1001100;
        else begin
            running = 1;
            mis = ex_valid && ex_is_branch && (ex_taken != ex_bpr);
            hlt = !mis && ex_valid && ex_halt;
            hz  = !mis && !hlt && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                  id_valid && reads[ex_rd];
            if (mis) begin
                ectl = 7'b0001110;
                epc  = ex_taken ? ex_target : ex_pc_next;
            end else if (hlt) ectl = 7'b1001100;
            else if (hz)      ectl = 7'b1100100;
            else              ectl = 7'b0000000;
        end
        octl = {pc_latchn, if_id_latchn, id_ex_latchn, if_id_flush, id_ex_flush,
                redirect_valid, halted};
        chk({tag, ".ctrl"}, 32'(octl), 32'(ectl));
        if (!RSTn || mis) chk({tag, ".rpc"}, 32'(redirect_pc), 32'(epc));
`ifdef PIPE_HAZARD_CTRL_STATS_EN
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
        chk({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(m_run));
`endif
        if (RSTn) begin
            if (running) begin
                m_run = sat_inc(m_run);
                if (mis) m_flush = sat_inc(m_flush);
                if (hz)  m_stall = sat_inc(m_stall);
                if (hlt) halt_at = cyc + int'(DRAIN_CYCLES) + 1;
            end
            cyc++;
        end
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from any clock edge
    task automatic pulse_reset(input string tag);
        @(negedge CLK);
        #2;
        RSTn    = 1'b0;
        cyc     = 0;
        halt_at = -1;
        m_stall = '0;
        m_flush = '0;
        m_run   = '0;
        check(tag);
        repeat (2) @(posedge CLK);
    endtask

    initial begin
        RSTn = 1'b0;
        next_cycle();
        RSTn = 1'b0;
        pulse_reset("por");

        next_cycle(); check("init");
        next_cycle(); check("run_idle");

        // Load-use on rs2, then the bubble clears it
        next_cycle();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
        id_valid = 1'b1; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        check("load_use");
        next_cycle(); id_valid = 1'b1; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        check("after_stall");

        // ex_rd = 0 and id_valid = 0 never stall
        next_cycle();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0;
        id_valid = 1'b1; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        check("rd_zero");
        next_cycle();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7;
        id_valid = 1'b0; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
        check("id_invalid");

        // Taken mispredict
        next_cycle();
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_bpr = 1'b0; ex_taken = 1'b1;
        ex_target = 12'h040; ex_pc_next = 12'h404;
        check("mispred_taken");

        // Not-taken mispredict combined with load-use: redirect wins, no stall
        next_cycle();
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3;
        ex_bpr = 1'b1; ex_taken = 1'b0; ex_target = 12'h7F0; ex_pc_next = 12'h01C;
        id_valid = 1'b1; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        check("mispred_nt_lu");

        // Correct prediction: no redirect
        next_cycle();
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_bpr = 1'b1; ex_taken = 1'b1;
        ex_target = 12'h123;
        check("pred_ok");

        // Halt, drain with an injected mispredict, then frozen
        next_cycle(); ex_valid = 1'b1; ex_halt = 1'b1;
        check("halt");
        next_cycle(); check("drain0");
        next_cycle();
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_bpr = 1'b0; ex_taken = 1'b1;
        ex_target = 12'h0AA;
        check("drain_mispred");
        next_cycle(); check("drain2");
        next_cycle(); check("halted0");
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9;
            id_valid = 1'b1; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
            check("halted_hold");
        end

        // Reset, halt again, and reset mid-drain with a mispredict presented
        pulse_reset("rst_halted");
        next_cycle(); check("init2");
        next_cycle(); ex_valid = 1'b1; ex_halt = 1'b1;
        check("halt2");
        next_cycle(); check("drain2_0");
        next_cycle();
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_bpr = 1'b1; ex_taken = 1'b0;
        ex_pc_next = 12'h55C;
        pulse_reset("rst_drain");
        next_cycle(); check("init3");
        next_cycle(); check("run3");

        // Randomized segments, each started from reset
        for (int s = 0; s < 8; s++) begin
            pulse_reset("rst_rand");
            for (int i = 0; i < 150; i++) begin
                next_cycle();
                ex_valid     = ($urandom_range(0, 3) != 0);
                ex_is_load   = 1'($urandom);
                ex_rd        = 5'($urandom_range(0, 3));
                id_valid     = ($urandom_range(0, 3) != 0);
                id_rs1       = 5'($urandom_range(0, 3));
                id_rs2       = 5'($urandom_range(0, 3));
                id_uses_rs1  = 1'($urandom);
                id_uses_rs2  = 1'($urandom);
                ex_is_branch = ($urandom_range(0, 2) == 0);
                ex_taken     = 1'($urandom);
                ex_bpr       = 1'($urandom);
                ex_target    = PC_W'($urandom);
                ex_pc_next   = PC_W'($urandom);
                ex_halt      = ($urandom_range(0, 59) == 0);
                check("rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
